// File: rtl/tiny_dnn_pkg.sv
// Shared types and field widths for the tiny-dnn accelerator and its layer sequencer.
package tiny_dnn_pkg;

  localparam int unsigned SS_W = 12;
  localparam int unsigned DD_W = 4;
  localparam int unsigned ID_W = 4;
  localparam int unsigned IS_W = 10;
  localparam int unsigned IH_W = 5;
  localparam int unsigned IW_W = 5;
  localparam int unsigned DS_W = 12;
  localparam int unsigned OD_W = 4;
  localparam int unsigned OS_W = 10;
  localparam int unsigned OH_W = 5;
  localparam int unsigned OW_W = 5;
  localparam int unsigned FS_W = 10;
  localparam int unsigned KS_W = 10;
  localparam int unsigned KH_W = 5;
  localparam int unsigned KW_W = 5;

  // Shape fields from MSB down, then the four flags in the low bits.
  typedef struct packed {
    logic [SS_W-1:0] ss;
    logic [DD_W-1:0] dd;
    logic [ID_W-1:0] id;
    logic [IS_W-1:0] is;
    logic [IH_W-1:0] ih;
    logic [IW_W-1:0] iw;
    logic [DS_W-1:0] ds;
    logic [OD_W-1:0] od;
    logic [OS_W-1:0] os;
    logic [OH_W-1:0] oh;
    logic [OW_W-1:0] ow;
    logic [FS_W-1:0] fs;
    logic [KS_W-1:0] ks;
    logic [KH_W-1:0] kh;
    logic [KW_W-1:0] kw;
    logic            backprop;
    logic            enbias;
    logic            has_w;
    logic            has_b;
  } layer_desc_t;

  localparam int unsigned DESC_W = $bits(layer_desc_t);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWload,
    StBload,
    StRun,
    StGap,
    StDone
  } seq_state_e;

endpackage

// File: rtl/layer_desc_ram.sv
// Layer descriptor table: synchronous write port, registered read port.
module layer_desc_ram #(
  parameter int unsigned L_MAX = 8,
  parameter int unsigned LA_W  = 3,
  parameter int unsigned DW    = 110
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [LA_W-1:0] waddr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [LA_W-1:0] raddr_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] mem_q [L_MAX];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/layer_seq.sv
// Multi-layer sequencer: walks a descriptor table and drives the accelerator's
// per-layer mode strobes and shape fields, advancing on observed stream handshakes.
module layer_seq
  import tiny_dnn_pkg::*;
#(
  parameter int unsigned L_MAX = 8,
  parameter int unsigned LA_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [LA_W-1:0]   cfg_addr,
  input  logic [DESC_W-1:0] cfg_data,
  input  logic [LA_W:0]     num_layers,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [LA_W-1:0]   cur_layer,
  output logic              backprop,
  output logic              enbias,
  output logic              run,
  output logic              wwrite,
  output logic              bwrite,
  output logic [SS_W-1:0]   ss,
  output logic [DD_W-1:0]   dd,
  output logic [ID_W-1:0]   id,
  output logic [IS_W-1:0]   is,
  output logic [IH_W-1:0]   ih,
  output logic [IW_W-1:0]   iw,
  output logic [DS_W-1:0]   ds,
  output logic [OD_W-1:0]   od,
  output logic [OS_W-1:0]   os,
  output logic [OH_W-1:0]   oh,
  output logic [OW_W-1:0]   ow,
  output logic [FS_W-1:0]   fs,
  output logic [KS_W-1:0]   ks,
  output logic [KH_W-1:0]   kh,
  output logic [KW_W-1:0]   kw,
  input  logic              src_valid,
  input  logic              src_ready,
  input  logic              src_last,
  input  logic              dst_valid,
  input  logic              dst_ready,
  input  logic              dst_last
);

  localparam logic [LA_W:0] LMax = (LA_W+1)'(L_MAX);

  seq_state_e        state_q, state_d;
  logic [LA_W:0]     cnt_q, cnt_d, n_q, n_d, cnt_inc;
  logic              abort_q, abort_d;
  layer_desc_t       desc_q, desc_d, rd_desc;
  logic [DESC_W-1:0] rd_data;
  logic [LA_W-1:0]   rd_addr;
  logic [LA_W-1:0]   cur_layer_q, cur_layer_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              wwrite_q, wwrite_d, bwrite_q, bwrite_d, run_q, run_d;
  logic              src_hs, dst_hs;
  logic              unused_has_w;

  assign src_hs  = src_valid & src_ready & src_last;
  assign dst_hs  = dst_valid & dst_ready & dst_last;
  assign cnt_inc = cnt_q + (LA_W+1)'(1);

  // Read is issued one cycle ahead of FETCH: layer 0 from IDLE, next layer from GAP.
  assign rd_addr = (state_q == StGap) ? cnt_inc[LA_W-1:0] : '0;
  assign rd_desc = layer_desc_t'(rd_data);

  layer_desc_ram #(
    .L_MAX (L_MAX),
    .LA_W  (LA_W),
    .DW    (DESC_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (cfg_we & (state_q == StIdle)),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    abort_d = abort_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          n_d     = (num_layers > LMax) ? LMax : num_layers;
          cnt_d   = '0;
          abort_d = 1'b0;
          state_d = (num_layers == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        if (rd_desc.has_w)      state_d = StWload;
        else if (rd_desc.has_b) state_d = StBload;
        else                    state_d = StRun;
      end
      StWload: if (src_hs) state_d = desc_q.has_b ? StBload : StRun;
      StBload: if (src_hs) state_d = StRun;
      StRun:   if (dst_hs) state_d = StGap;
      StGap: begin
        cnt_d   = cnt_inc;
        state_d = (abort_q || abort || cnt_inc >= n_q) ? StDone : StFetch;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort && (state_q == StFetch || state_q == StWload ||
                  state_q == StBload || state_q == StRun)) begin
      state_d = StGap;
      abort_d = 1'b1;
    end
  end

  // Output registers are loaded from the next state so every output is a flop.
  always_comb begin
    desc_d      = (state_q == StFetch) ? rd_desc : desc_q;
    cur_layer_d = cur_layer_q;
    if (state_d == StFetch) begin
      cur_layer_d = (state_q == StGap) ? cnt_inc[LA_W-1:0] : '0;
    end
    busy_d   = (state_d != StIdle);
    done_d   = (state_d == StDone);
    wwrite_d = (state_d == StWload);
    bwrite_d = (state_d == StBload);
    run_d    = (state_d == StRun);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      n_q         <= '0;
      abort_q     <= 1'b0;
      desc_q      <= '0;
      cur_layer_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wwrite_q    <= 1'b0;
      bwrite_q    <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      abort_q     <= abort_d;
      desc_q      <= desc_d;
      cur_layer_q <= cur_layer_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wwrite_q    <= wwrite_d;
      bwrite_q    <= bwrite_d;
      run_q       <= run_d;
    end
  end

  assign unused_has_w = desc_q.has_w;

  assign busy      = busy_q;
  assign done      = done_q;
  assign cur_layer = cur_layer_q;
  assign wwrite    = wwrite_q;
  assign bwrite    = bwrite_q;
  assign run       = run_q;
  assign backprop  = desc_q.backprop;
  assign enbias    = desc_q.enbias;
  assign ss        = desc_q.ss;
  assign dd        = desc_q.dd;
  assign id        = desc_q.id;
  assign is        = desc_q.is;
  assign ih        = desc_q.ih;
  assign iw        = desc_q.iw;
  assign ds        = desc_q.ds;
  assign od        = desc_q.od;
  assign os        = desc_q.os;
  assign oh        = desc_q.oh;
  assign ow        = desc_q.ow;
  assign fs        = desc_q.fs;
  assign ks        = desc_q.ks;
  assign kh        = desc_q.kh;
  assign kw        = desc_q.kw;

endmodule

// File: tb/tb_layer_seq.sv
// Randomized bench for layer_seq against a queue-of-phases reference model.
module tb_layer_seq;
  import tiny_dnn_pkg::*;

  localparam int unsigned LMAX = 8;

  logic              clk;
  logic              rst;
  logic              cfg_we;
  logic [2:0]        cfg_addr;
  logic [DESC_W-1:0] cfg_data;
  logic [3:0]        num_layers;
  logic              start, abort;
  logic              busy, done;
  logic [2:0]        cur_layer;
  logic              backprop, enbias, run, wwrite, bwrite;
  logic [SS_W-1:0]   ss;
  logic [DD_W-1:0]   dd;
  logic [ID_W-1:0]   id;
  logic [IS_W-1:0]   is;
  logic [IH_W-1:0]   ih;
  logic [IW_W-1:0]   iw;
  logic [DS_W-1:0]   ds;
  logic [OD_W-1:0]   od;
  logic [OS_W-1:0]   os;
  logic [OH_W-1:0]   oh;
  logic [OW_W-1:0]   ow;
  logic [FS_W-1:0]   fs;
  logic [KS_W-1:0]   ks;
  logic [KH_W-1:0]   kh;
  logic [KW_W-1:0]   kw;
  logic src_valid, src_ready, src_last, dst_valid, dst_ready, dst_last;

  layer_seq #(.L_MAX(8), .LA_W(3)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .num_layers(num_layers), .start(start), .abort(abort), .busy(busy), .done(done),
    .cur_layer(cur_layer), .backprop(backprop), .enbias(enbias), .run(run),
    .wwrite(wwrite), .bwrite(bwrite), .ss(ss), .dd(dd), .id(id), .is(is), .ih(ih),
    .iw(iw), .ds(ds), .od(od), .os(os), .oh(oh), .ow(ow), .fs(fs), .ks(ks), .kh(kh),
    .kw(kw), .src_valid(src_valid), .src_ready(src_ready), .src_last(src_last),
    .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_last(dst_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: expected activity is a queue of phase slots built at start.
  typedef struct packed {
    logic [7:0] kind;
    logic [7:0] layer;
  } slot_t;

  slot_t             q[$];
  logic [DESC_W-1:0] tbl [LMAX];
  logic [DESC_W-1:0] m_desc;
  logic [2:0]        m_cur;
  int                ph_cyc;
  int                mode;
  int                n_checks, n_pass;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic slot_t mk(input logic [7:0] k, input int l);
    slot_t s;
    s.kind  = k;
    s.layer = 8'(l);
    return s;
  endfunction

  task automatic build();
    int n;
    n = (num_layers > 4'(LMAX)) ? LMAX : int'(num_layers);
    for (int i = 0; i < n; i++) begin
      q.push_back(mk("F", i));
      if (tbl[i][1]) q.push_back(mk("W", i));
      if (tbl[i][0]) q.push_back(mk("B", i));
      q.push_back(mk("R", i));
      q.push_back(mk("G", i));
    end
    q.push_back(mk("D", 0));
  endtask

  task automatic model_edge();
    slot_t f;
    bit    popped;
    bit    src_hs, dst_hs;
    popped = 1'b0;
    src_hs = src_valid & src_ready & src_last;
    dst_hs = dst_valid & dst_ready & dst_last;
    if (rst) begin
      q.delete();
      m_cur  = '0;
      m_desc = '0;
      ph_cyc = 0;
      return;
    end
    if (q.size() == 0) begin
      if (start) begin
        build();
        popped = 1'b1;
      end
      if (cfg_we) tbl[cfg_addr] = cfg_data;
    end else begin
      f = q[0];
      if (f.kind == "F") m_desc = tbl[f.layer[2:0]];
      if (abort && (f.kind == "F" || f.kind == "W" || f.kind == "B" || f.kind == "R")) begin
        q.delete();
        q.push_back(mk("G", 0));
        q.push_back(mk("D", 0));
        popped = 1'b1;
      end else if (abort && f.kind == "G") begin
        q.delete();
        q.push_back(mk("D", 0));
        popped = 1'b1;
      end else if (f.kind == "F" || f.kind == "G" || f.kind == "D" ||
                   ((f.kind == "W" || f.kind == "B") && src_hs) ||
                   (f.kind == "R" && dst_hs)) begin
        void'(q.pop_front());
        popped = 1'b1;
      end
    end
    if (popped) ph_cyc = 0;
    else ph_cyc++;
    if (q.size() > 0 && q[0].kind == "F") m_cur = q[0].layer[2:0];
  endtask

  task automatic compare();
    logic [7:0] k;
    logic [4:0] exp_ctrl;
    k = (q.size() > 0) ? q[0].kind : 8'h0;
    exp_ctrl = {q.size() > 0, k == "D", k == "W", k == "B", k == "R"};
    check("ctrl{busy,done,wwrite,bwrite,run}", 128'({busy, done, wwrite, bwrite, run}),
          128'(exp_ctrl));
    check("cur_layer", 128'(cur_layer), 128'(m_cur));
    check("shape+flags", 128'({ss, dd, id, is, ih, iw, ds, od, os, oh, ow, fs, ks, kh, kw,
                               backprop, enbias}), 128'(m_desc[DESC_W-1:2]));
  endtask

  task automatic drive_hs();
    logic [7:0] k;
    k = (q.size() > 0) ? q[0].kind : 8'h0;
    case (mode)
      1: begin  // every beat handshakes; last on beat 25 of a load, beat 3 of run
        src_valid = 1'b1; src_ready = 1'b1;
        src_last  = (k == "R") ? 1'b1 : (ph_cyc == 24);
        dst_valid = 1'b1; dst_ready = 1'b1;
        dst_last  = (k == "R") && (ph_cyc == 2);
      end
      2: begin  // last beat presented but stalled for 5 cycles
        src_valid = 1'b1; src_last = 1'b1; src_ready = (ph_cyc >= 5);
        dst_valid = 1'b1; dst_ready = 1'b1; dst_last = 1'b1;
      end
      default: begin
        src_valid = 1'($urandom % 2); src_ready = 1'($urandom % 2);
        src_last  = ($urandom % 4) == 0;
        dst_valid = 1'($urandom % 2); dst_ready = 1'($urandom % 2);
        dst_last  = ($urandom % 4) == 0;
      end
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    start  = 1'b0;
    abort  = 1'b0;
    cfg_we = 1'b0;
    drive_hs();
  endtask

  function automatic logic [DESC_W-1:0] rnd_desc();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[DESC_W-1:0];
  endfunction

  task automatic wr(input int a, input logic [DESC_W-1:0] d);
    cfg_we   = 1'b1;
    cfg_addr = 3'(a);
    cfg_data = d;
    cycle();
  endtask

  task automatic run_seq(input int n, input int abort_at, input bit noise);
    int k;
    start      = 1'b1;
    num_layers = 4'(n);
    cycle();
    k = 0;
    while (q.size() > 0 && k < 3000) begin
      if (k == abort_at) abort = 1'b1;
      if (noise) begin
        cfg_we     = 1'($urandom % 2);
        cfg_addr   = 3'($urandom);
        cfg_data   = rnd_desc();
        start      = 1'($urandom % 2);
        num_layers = 4'($urandom);
      end
      cycle();
      k++;
    end
    check("sequence_finished", 128'(q.size()), 128'(0));
  endtask

  layer_desc_t s;

  initial begin
    n_checks = 0; n_pass = 0; mode = 0; ph_cyc = 0;
    m_cur = '0; m_desc = '0;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; num_layers = '0;
    start = 1'b0; abort = 1'b0;
    src_valid = 1'b0; src_ready = 1'b0; src_last = 1'b0;
    dst_valid = 1'b0; dst_ready = 1'b0; dst_last = 1'b0;
    for (int i = 0; i < int'(LMAX); i++) tbl[i] = '0;
    cycle(); cycle();
    rst = 1'b0;
    cycle();

    // Single layer, weights only, src_last on beat 25.
    s = layer_desc_t'(rnd_desc()); s.has_w = 1'b1; s.has_b = 1'b0;
    wr(0, s);
    mode = 1;
    run_seq(1, -1, 1'b0);

    // Three layers with distinct od values.
    for (int i = 0; i < 3; i++) begin
      s = layer_desc_t'(rnd_desc());
      s.od = (i == 0) ? 4'd1 : (i == 1) ? 4'd6 : 4'd10;
      wr(i, s);
    end
    mode = 0;
    run_seq(3, -1, 1'b0);

    // Zero layers.
    run_seq(0, -1, 1'b0);

    // Abort mid-WLOAD of layer 0 of 2.
    s = layer_desc_t'(rnd_desc()); s.has_w = 1'b1;
    wr(0, s);
    wr(1, rnd_desc());
    mode = 2;
    run_seq(2, 3, 1'b0);

    // Stalled last beat.
    run_seq(1, -1, 1'b0);

    // Writes and start while busy, then the same table replayed.
    mode = 0;
    run_seq(3, -1, 1'b1);
    run_seq(3, -1, 1'b0);

    // Layer count above the table depth.
    for (int i = 0; i < int'(LMAX); i++) wr(i, rnd_desc());
    run_seq(12, -1, 1'b0);

    // Reset in the middle of a sequence.
    start = 1'b1; num_layers = 4'd2;
    cycle();
    repeat (6) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (3) cycle();

    for (int it = 0; it < 12; it++) begin
      if ($urandom % 2 == 0) for (int i = 0; i < int'(LMAX); i++) wr(i, rnd_desc());
      run_seq($urandom_range(0, 9), ($urandom % 3 == 0) ? $urandom_range(0, 30) : -1,
              1'($urandom % 2));
      repeat (2) cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
